rv32_decode_stage: RTL

Registered RV32I/RV32M decode pipeline stage. It sits between the fetch stage and the register-file/execute stage. It accepts one instruction per cycle over a valid/ready handshake and splits it into register addresses, the ALU op, the funct3 field and a sign-extended immediate. It flags illegal encodings and holds its result stable under back-pressure. Field decode, ALU op coding and immediate formats are unchanged from the existing combinational decoder. This block adds the pipeline register, flush, optional M-extension ops and illegal-instruction detection.

---
 rtl/rv32_decode_stage.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/rv32_decode_stage.sv
// rv32_decode_stage
//   Registered RV32I (+ optional RV32M) decode stage between fetch and
//   register-file/execute. One instruction per cycle over valid/ready.
//
// Parameters
//   PC_W   width of the program counter carried with the instruction
//   M_EXT  1 = decode RV32M ops (R_TYPE funct7 0000001), 0 = treat as illegal
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid/in_ready           fetch-side handshake (in_ready is combinational)
//   in_inst, in_pc              instruction word and its address
//   flush                       kill held instruction and any accepted this cycle
//   rs1_rd_addr, rs2_rd_addr    combinational source addresses for a synchronous
//                               register-file read aligned with the outputs
//   out_valid/out_ready         execute-side handshake
//   out_pc, rs1_addr, rs2_addr, rd_addr, opcode, funct3   registered raw fields
//   op, imm, illegal            registered decode results
module rv32_decode_stage #(
  parameter int PC_W  = 32,
  parameter bit M_EXT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic [4:0]      rs1_rd_addr,
  output logic [4:0]      rs2_rd_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [4:0]      op,
  output logic [31:0]     imm,
  output logic            illegal
);

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_SLT = 5'd2,  OP_SLTU = 5'd3,
    OP_XOR  = 5'd4,  OP_OR   = 5'd5,  OP_AND = 5'd6,  OP_SLL  = 5'd7,
    OP_SRL  = 5'd8,  OP_SRA  = 5'd9,  OP_EQ  = 5'd10, OP_NEQ  = 5'd11,
    OP_GE   = 5'd12, OP_GEU  = 5'd13
  } alu_op_e;

  // ALU op selected by funct3 for R_TYPE/I_TYPE. alt is inst[30]; the SUB
  // variant exists only for R_TYPE, the SRA variant for both.
  function automatic alu_op_e base_op(input logic [2:0] f3, input logic alt,
                                      input logic sub_ok);
    case (f3)
      3'b000:  return (alt && sub_ok) ? OP_SUB : OP_ADD;
      3'b001:  return OP_SLL;
      3'b010:  return OP_SLT;
      3'b011:  return OP_SLTU;
      3'b100:  return OP_XOR;
      3'b101:  return alt ? OP_SRA : OP_SRL;
      3'b110:  return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [4:0]  dec_op;
  logic [31:0] dec_imm;
  logic        dec_illegal;
  logic        load;

  assign f7          = in_inst[31:25];
  assign f3          = in_inst[14:12];
  assign rs1_rd_addr = in_inst[19:15];
  assign rs2_rd_addr = in_inst[24:20];
  assign in_ready    = !out_valid || out_ready;
  assign load        = in_valid && in_ready && !flush;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    dec_op      = OP_ADD;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    case (in_inst[6:0])
      OPC_R: begin
        if (f7 == 7'b0000001) begin
          if (M_EXT) dec_op = {2'b10, f3};  // MUL..REMU = 16 + funct3
          else       dec_illegal = 1'b1;
        end else if (f7 == 7'b0000000 ||
                     (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) begin
          dec_op = base_op(f3, in_inst[30], 1'b1);
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_I: begin
        dec_op  = base_op(f3, in_inst[30], 1'b0);
        dec_imm = {{20{in_inst[31]}}, in_inst[31:20]};
        if ((f3 == 3'b001 && f7 != 7'b0000000) ||
            (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000))
          dec_illegal = 1'b1;
      end
      OPC_LOAD: begin
        dec_imm     = {{20{in_inst[31]}}, in_inst[31:20]};
        dec_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        dec_imm     = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        dec_illegal = (f3 >= 3'b011);
      end
      OPC_BRANCH: begin
        dec_imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                   in_inst[11:8], 1'b0};
        case (f3)
          3'b000:  dec_op = OP_EQ;
          3'b001:  dec_op = OP_NEQ;
          3'b100:  dec_op = OP_SLT;
          3'b101:  dec_op = OP_GE;
          3'b110:  dec_op = OP_SLTU;
          3'b111:  dec_op = OP_GEU;
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_JAL: begin
        dec_imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                   in_inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        dec_imm     = {{20{in_inst[31]}}, in_inst[31:20]};
        dec_illegal = (f3 != 3'b000);
      end
      OPC_LUI, OPC_AUIPC: dec_imm = {in_inst[31:12], 12'h000};
      OPC_SYSTEM, OPC_FENCE: ;
      default: dec_illegal = 1'b1;
    endcase
    // Illegal words travel downstream with neutral op/imm so execute never
    // acts on a half-decoded instruction.
    if (dec_illegal) begin
      dec_op  = OP_ADD;
      dec_imm = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples pre-edge values regardless of block ordering.
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Data registers only move on load, so flush and stalls leave them intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pc   <= '0;
      rs1_addr <= '0;
      rs2_addr <= '0;
      rd_addr  <= '0;
      opcode   <= '0;
      funct3   <= '0;
      op       <= '0;
      imm      <= '0;
      illegal  <= 1'b0;
    end else if (load) begin
      out_pc   <= in_pc;
      rs1_addr <= in_inst[19:15];
      rs2_addr <= in_inst[24:20];
      rd_addr  <= in_inst[11:7];
      opcode   <= in_inst[6:0];
      funct3   <= f3;
      op       <= dec_op;
      imm      <= dec_imm;
      illegal  <= dec_illegal;
    end
  end

endmodule
